// File: rtl/dfa_lookahead_multiport_ram.sv
`timescale 1ns/1ps
// dfa_lookahead_multiport_ram
//
// Lookahead multiport memory for the DFA data path. It has one write port with
// byte enables and NUM_RD_PORTS independent registered read ports. Each read
// port bypasses a write to the same word at the same edge, so a read always
// returns the post-write value. A small state machine zeroes the memory after
// reset (when CLEAR_ON_RESET=1) and on a run-time clear_req pulse. While it is
// clearing, it holds off the write master through wr_waitrequest.
//
// Ports
//   clk             sole clock, rising edge
//   reset_n         asynchronous active-low reset
//   wr_address      write word address
//   wr_writedata    write data
//   wr_byteenable   per-symbol write enable (bit i -> symbol i)
//   wr_write        write request
//   wr_waitrequest  1 = write not accepted this cycle (registered)
//   clear_req       single-cycle pulse requesting a full clear
//   rd_address      packed read addresses, port p at [p*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   rd_readdata     packed registered read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
module dfa_lookahead_multiport_ram #(
  parameter  int DEPTH          = 16,
  parameter  int DATA_WIDTH     = 32,
  parameter  int SYMBOL_WIDTH   = 8,
  parameter  int ADDRESS_WIDTH  = 4,
  parameter  int NUM_RD_PORTS   = 2,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int NUM_SYMBOLS    = DATA_WIDTH / SYMBOL_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [ADDRESS_WIDTH-1:0]             wr_address,
  input  logic [DATA_WIDTH-1:0]                wr_writedata,
  input  logic [NUM_SYMBOLS-1:0]               wr_byteenable,
  input  logic                                 wr_write,
  output logic                                 wr_waitrequest,
  input  logic                                 clear_req,
  input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rd_address,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rd_readdata
);

  // Index width for the storage array. It is at least one bit so that
  // DEPTH=1 still gets a legal counter.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  // One extra bit so that DEPTH == 2**ADDRESS_WIDTH can still be represented.
  localparam logic [ADDRESS_WIDTH:0] DEPTH_LIMIT = (ADDRESS_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    CLEARING,
    READY
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] counter_reg, counter_next;
  logic             clear_active_reg, clear_active_next;
  logic             waitrequest_reg, waitrequest_next;

  logic             wr_accept;
  logic             wr_in_range;
  logic             clear_write;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign wr_waitrequest = waitrequest_reg;
  assign wr_accept      = wr_write && !waitrequest_reg;
  assign wr_in_range    = {1'b0, wr_address} < DEPTH_LIMIT;
  // clear_active_reg tells a reset-entered CLEARING with CLEAR_ON_RESET=0
  // (no writes, leave at once) apart from a real clear. A run-time clear
  // always sets it.
  assign clear_write    = (state_reg == CLEARING) && clear_active_reg;

  // ---------------------------------------------------------------------------
  // Clear sequencer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= CLEARING;
      counter_reg      <= LAST_IDX;
      clear_active_reg <= (CLEAR_ON_RESET != 0);
      waitrequest_reg  <= 1'b1;
    end else begin
      state_reg        <= state_next;
      counter_reg      <= counter_next;
      clear_active_reg <= clear_active_next;
      waitrequest_reg  <= waitrequest_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear sequencer: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    counter_next      = counter_reg;
    clear_active_next = clear_active_reg;
    waitrequest_next  = waitrequest_reg;

    case (state_reg)
      CLEARING: begin
        // Any clear_req arriving here is ignored. The counter keeps running.
        if (!clear_active_reg || (counter_reg == '0)) begin
          state_next       = READY;
          waitrequest_next = 1'b0;
        end else begin
          counter_next = counter_reg - IDX_W'(1);
        end
      end
      READY: begin
        if (clear_req) begin
          state_next        = CLEARING;
          counter_next      = LAST_IDX;
          clear_active_next = 1'b1;
          waitrequest_next  = 1'b1;
        end
      end
      default: begin
        state_next       = CLEARING;
        counter_next     = LAST_IDX;
        waitrequest_next = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage. Clear writes and master writes cannot both happen in one cycle,
  // because wr_waitrequest is high for the whole of CLEARING.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clear_write) begin
      mem[counter_reg] <= '0;
    end else if (wr_accept && wr_in_range) begin
      for (int s = 0; s < NUM_SYMBOLS; s++) begin
        if (wr_byteenable[s]) begin
          mem[wr_address[IDX_W-1:0]][s*SYMBOL_WIDTH +: SYMBOL_WIDTH] <=
            wr_writedata[s*SYMBOL_WIDTH +: SYMBOL_WIDTH];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports. Each port registers its word at every edge. When an accepted
  // write targets the same word at that same edge, the enabled symbols come
  // from the write data and the rest come from the stored word. The result is
  // the post-write value. An out-of-range address never bypasses and reads 0.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     in_range;
    logic                     hit;
    logic [DATA_WIDTH-1:0]    stored;
    logic [DATA_WIDTH-1:0]    merged;
    logic [DATA_WIDTH-1:0]    data_reg;

    assign addr     = rd_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign in_range = {1'b0, addr} < DEPTH_LIMIT;
    assign hit      = wr_accept && wr_in_range && (wr_address == addr);
    assign stored   = in_range ? mem[addr[IDX_W-1:0]] : '0;

    for (genvar gs = 0; gs < NUM_SYMBOLS; gs++) begin : g_sym
      assign merged[gs*SYMBOL_WIDTH +: SYMBOL_WIDTH] =
        (hit && wr_byteenable[gs]) ? wr_writedata[gs*SYMBOL_WIDTH +: SYMBOL_WIDTH]
                                   : stored[gs*SYMBOL_WIDTH +: SYMBOL_WIDTH];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_reg <= '0;
      end else if ((state_reg == CLEARING) || !in_range) begin
        data_reg <= '0;
      end else begin
        data_reg <= merged;
      end
    end

    assign rd_readdata[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg;
  end

endmodule

// File: tb/tb_dfa_lookahead_multiport_ram.sv
`timescale 1ns/1ps
// Scoreboard bench for dfa_lookahead_multiport_ram (DEPTH=12, 3 read ports).
// The stimulus pushes the expected per-edge response into a queue. A monitor
// pops the queue on the falling edge and compares it with the DUT outputs.
module tb_dfa_lookahead_multiport_ram;

  localparam int DEPTH = 12;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NP    = 3;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [AW-1:0]      wr_address = '0;
  logic [DW-1:0]      wr_writedata = '0;
  logic [3:0]         wr_byteenable = '0;
  logic               wr_write = 1'b0;
  logic               wr_waitrequest;
  logic               clear_req = 1'b0;
  logic [NP*AW-1:0]   rd_address = '0;
  logic [NP*DW-1:0]   rd_readdata;

  dfa_lookahead_multiport_ram #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .SYMBOL_WIDTH(8), .ADDRESS_WIDTH(AW),
    .NUM_RD_PORTS(NP), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_address(wr_address), .wr_writedata(wr_writedata),
    .wr_byteenable(wr_byteenable), .wr_write(wr_write),
    .wr_waitrequest(wr_waitrequest), .clear_req(clear_req),
    .rd_address(rd_address), .rd_readdata(rd_readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  edge_no;
    logic [NP-1:0][31:0] rd;
    logic                wr;
    bit                  h_en;
    int                  h_port;
    logic [31:0]         h_val;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   total = 0;
  int   bad = 0;

  // Mirror model state
  logic [31:0] m_mem [DEPTH];
  bit          m_busy;
  int          m_left;

  // Hand-computed expectation attached to the next step
  bit          h_en = 0;
  int          h_port = 0;
  logic [31:0] h_val = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: outputs are checked half a cycle after the edge they belong to.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
      e = sb.pop_front();
      total++;
      if (wr_waitrequest !== e.wr) begin
        bad++;
        $display("FAIL waitreq edge=%0d got=%b want=%b", e.edge_no, wr_waitrequest, e.wr);
      end
      for (int p = 0; p < NP; p++) begin
        total++;
        if (rd_readdata[p*DW +: DW] !== e.rd[p]) begin
          bad++;
          $display("FAIL rd%0d edge=%0d got=%h want=%h", p, e.edge_no, rd_readdata[p*DW +: DW], e.rd[p]);
        end
      end
      if (e.h_en) begin
        total++;
        if (rd_readdata[e.h_port*DW +: DW] !== e.h_val) begin
          bad++;
          $display("FAIL directed rd%0d edge=%0d got=%h want=%h", e.h_port, e.edge_no,
                   rd_readdata[e.h_port*DW +: DW], e.h_val);
        end
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int s = 0; s < 4; s++) if (be[s]) r[s*8 +: 8] = new_v[s*8 +: 8];
    return r;
  endfunction

  // Drive one cycle's inputs, predict the result of the next edge, then advance.
  task automatic step(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input bit clr,
                      input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2);
    exp_t        e;
    logic [3:0]  ra [NP];
    bit          acc;
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
    wr_write = we; wr_address = wa; wr_writedata = wd; wr_byteenable = be;
    clear_req = clr;
    rd_address = {r2, r1, r0};
    e.edge_no = edge_cnt + 1;
    e.h_en = h_en; e.h_port = h_port; e.h_val = h_val;
    h_en = 0;
    if (!reset_n) begin
      for (int p = 0; p < NP; p++) e.rd[p] = '0;
      m_busy = 1; m_left = DEPTH;
      e.wr = 1'b1;
    end else begin
      acc = we && !m_busy;
      for (int p = 0; p < NP; p++) begin
        if (m_busy || int'(ra[p]) >= DEPTH) e.rd[p] = '0;
        else if (acc && wa == ra[p]) e.rd[p] = merge(m_mem[ra[p]], wd, be);
        else e.rd[p] = m_mem[ra[p]];
      end
      if (m_busy) begin
        m_left--;
        if (m_left == 0) m_busy = 0;
      end else begin
        if (acc && int'(wa) < DEPTH) m_mem[wa] = merge(m_mem[wa], wd, be);
        if (clr) begin
          for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
          m_busy = 1; m_left = DEPTH;
        end
      end
      e.wr = m_busy;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 32'd0, 4'h0, 0, 4'd0, 4'd1, 4'd2);
  endtask

  task automatic expect_hand(input int port, input logic [31:0] v);
    h_en = 1; h_port = port; h_val = v;
  endtask

  // Reset is asserted asynchronously, one time unit after a rising edge.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    idle(n);
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_busy = 1; m_left = DEPTH;

    // Reset and initial clear: waitrequest high for DEPTH edges, memory reads 0.
    do_reset(3);
    idle(DEPTH + 1);
    for (int a = 0; a < DEPTH; a++) begin
      expect_hand(0, 32'h0);
      step(0, 4'd0, 32'd0, 4'h0, 0, 4'(a), 4'(DEPTH - 1 - a), 4'(a));
    end

    // Same-edge bypass on port 0, then a normal read on port 1.
    expect_hand(0, 32'hAABBCCDD);
    step(1, 4'd3, 32'hAABBCCDD, 4'hF, 0, 4'd3, 4'd0, 4'd5);
    expect_hand(1, 32'hAABBCCDD);
    step(0, 4'd0, 32'd0, 4'h0, 0, 4'd0, 4'd3, 4'd3);

    // Partial byte-enable merge during a same-edge read.
    step(1, 4'd3, 32'h11223344, 4'hF, 0, 4'd0, 4'd0, 4'd0);
    expect_hand(1, 32'h11EE33CC);
    step(1, 4'd3, 32'hFFEEDDCC, 4'b0101, 0, 4'd1, 4'd3, 4'd2);
    // A write with no byte enables changes nothing.
    expect_hand(2, 32'h11EE33CC);
    step(1, 4'd3, 32'h00000000, 4'h0, 0, 4'd3, 4'd1, 4'd3);

    // clear_req with a same-cycle write: the write is accepted, then cleared.
    step(1, 4'd9, 32'hCAFEF00D, 4'hF, 0, 4'd9, 4'd9, 4'd9);
    expect_hand(0, 32'h00000005);
    step(1, 4'd7, 32'h00000005, 4'hF, 1, 4'd7, 4'd9, 4'd3);
    idle(4);
    // A second clear_req and a write while busy are both ignored.
    step(1, 4'd2, 32'h00000099, 4'hF, 1, 4'd2, 4'd7, 4'd9);
    idle(10);
    expect_hand(0, 32'h0);
    step(0, 4'd0, 32'd0, 4'h0, 0, 4'd7, 4'd2, 4'd9);
    expect_hand(1, 32'h0);
    step(0, 4'd0, 32'd0, 4'h0, 0, 4'd3, 4'd2, 4'd9);

    // Out-of-range write and reads.
    expect_hand(2, 32'h0);
    step(1, 4'd13, 32'hDEADBEEF, 4'hF, 0, 4'd13, 4'd12, 4'd13);
    for (int a = 0; a < 16; a++) step(0, 4'd0, 32'd0, 4'h0, 0, 4'(a), 4'(15 - a), 4'd13);

    // Reset in the middle of a clear restarts the full sequence.
    step(1, 4'd4, 32'h01020304, 4'hF, 0, 4'd4, 4'd0, 4'd0);
    step(0, 4'd0, 32'd0, 4'h0, 1, 4'd4, 4'd0, 4'd0);
    idle(5);
    do_reset(2);
    idle(DEPTH + 2);
    expect_hand(0, 32'h0);
    step(0, 4'd0, 32'd0, 4'h0, 0, 4'd4, 4'd0, 4'd0);

    // Random traffic against the mirror model.
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] wa;
      wa = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)));
    end
    idle(2);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
